inst_queue: RTL and testbench

- Circular FIFO between the fetch stage and decode/dispatch.
- Buffers fetched (instruction, pc) pairs and tells fetch when to stop.
- Presents the oldest entry to the decoder with a valid/ready handshake.
- Flushes all contents on a ROB mispredict/jump.

---
 rtl/inst_queue_pkg.sv | 18 +
 rtl/inst_queue_if.sv | 23 ++
 rtl/inst_queue_storage.sv | 24 ++
 rtl/inst_queue.sv | 73 +++++++
 tb/tb_inst_queue.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package inst_queue_pkg;
   localparam int INST_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int IQ_DEPTH = 16;
   localparam int IQ_PTR_W = 4;

   localparam logic IQ_FULL     = 1'b1;
   localparam logic IQ_NOT_FULL = 1'b0;

   typedef logic [INST_W-1:0] inst_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef struct packed {
      inst_t inst;
      addr_t pc;
   } iq_entry_t;
endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface inst_queue_if;
   import inst_queue_pkg::*;

   logic  IF_inst_valid;
   inst_t IF_inst;
   addr_t IF_pc;
   logic  IF_queue_is_full;
   logic  Dec_ready;
   logic  Dec_inst_valid;
   inst_t Dec_inst;
   addr_t Dec_pc;

   modport slave (
      input  IF_inst_valid, IF_inst, IF_pc, Dec_ready,
      output IF_queue_is_full, Dec_inst_valid, Dec_inst, Dec_pc
   );

   modport master (
      output IF_inst_valid, IF_inst, IF_pc, Dec_ready,
      input  IF_queue_is_full, Dec_inst_valid, Dec_inst, Dec_pc
   );
endinterface

// File: rtl/inst_queue_storage.sv
// Entry storage: one write port, asynchronous read so the head is shown ahead.
module inst_queue_storage
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  iq_entry_t        wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output iq_entry_t        rdata_o
);
   iq_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode, flushed by the ROB.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int PTR_W = IQ_PTR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic         ROB_jump_judge,
   inst_queue_if.slave  iq
);
   localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] FULL_TH_C = (PTR_W+1)'(DEPTH - 2);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             flush, push, pop;
   iq_entry_t        head_entry;

   assign flush = rdy & ROB_jump_judge;
   assign push  = rdy & iq.IF_inst_valid & ~flush & (count_q != DEPTH_C);
   assign pop   = rdy & iq.Dec_ready & (count_q != '0) & ~flush;

   // Pointers wrap for free because DEPTH is exactly 2**PTR_W.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   inst_queue_storage #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_storage (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (tail_q),
      .wdata_i ({iq.IF_inst, iq.IF_pc}),
      .raddr_i (head_q),
      .rdata_o (head_entry)
   );

   // Two-slot margin covers the push already in flight from a registered fetch.
   assign iq.IF_queue_is_full = (count_q >= FULL_TH_C) ? IQ_FULL : IQ_NOT_FULL;
   assign iq.Dec_inst_valid   = (count_q != '0);
   assign iq.Dec_inst         = head_entry.inst;
   assign iq.Dec_pc           = head_entry.pc;
endmodule

// File: tb/tb_inst_queue.sv
// Randomised self-checking bench for inst_queue against a queue-based model.
module tb_inst_queue;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rdy = 1'b0;
   logic rob_jump = 1'b0;

   inst_queue_if iq();

   inst_queue #(.DEPTH(DEPTH), .PTR_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .ROB_jump_judge (rob_jump),
      .iq             (iq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   logic [63:0] model_q[$];
   logic [31:0] popped_pc[$];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: plain FIFO semantics evaluated at each edge from the sampled inputs.
   always @(posedge clk) begin
      logic [63:0] e;
      logic        do_pop;
      if (rst && rdy) begin
         if (rob_jump) begin
            model_q.delete();
         end else begin
            do_pop = iq.Dec_ready && (model_q.size() != 0);
            if (iq.IF_inst_valid)
               check("no_overflow", 64'(model_q.size() == DEPTH), 64'(0));
            if (do_pop) begin
               e = model_q.pop_front();
               popped_pc.push_back(e[31:0]);
            end
            if (iq.IF_inst_valid && model_q.size() < DEPTH)
               model_q.push_back({iq.IF_inst, iq.IF_pc});
         end
      end
   end

   always @(negedge rst) model_q.delete();

   always @(negedge clk) begin
      if (chk_en && rst) begin
         check("valid", 64'(iq.Dec_inst_valid), 64'(model_q.size() != 0));
         check("full", 64'(iq.IF_queue_is_full), 64'(model_q.size() >= DEPTH - 2));
         if (model_q.size() != 0)
            check("head", {iq.Dec_inst, iq.Dec_pc}, model_q[0]);
      end
   end

   task automatic cyc(bit v, logic [31:0] pc, bit dr, bit r = 1'b1, bit j = 1'b0);
      iq.IF_inst_valid = v;
      iq.IF_pc         = pc;
      iq.IF_inst       = $urandom;
      iq.Dec_ready     = dr;
      rdy              = r;
      rob_jump         = j;
      @(negedge clk);
      #1;
      $display("cyc t=%0t v=%0b pc=%h dr=%0b rdy=%0b jmp=%0b -> dec_v=%0b dec_pc=%h full=%0b",
               $time, v, pc, dr, r, j, iq.Dec_inst_valid, iq.Dec_pc, iq.IF_queue_is_full);
   endtask

   initial begin
      int  n;
      bit  full_d;
      bit  v;
      iq.IF_inst_valid = 1'b0;
      iq.IF_inst       = '0;
      iq.IF_pc         = '0;
      iq.Dec_ready     = 1'b0;
      #1;
      check("rst_valid", 64'(iq.Dec_inst_valid), 64'(0));
      check("rst_full", 64'(iq.IF_queue_is_full), 64'(0));
      @(negedge clk); @(negedge clk); #1;
      rst    = 1'b1;
      chk_en = 1'b1;

      // Fill with a fetch stage that reacts to full one cycle late.
      full_d = 1'b0;
      n = 0;
      repeat (20) begin
         v = !full_d;
         full_d = iq.IF_queue_is_full;
         cyc(v, 32'(n * 4), 1'b0);
         if (v) n++;
      end
      check("fill_accepted", 64'(n), 64'(15));
      check("fill_head_pc", 64'(iq.Dec_pc), 64'(0));
      check("fill_full", 64'(iq.IF_queue_is_full), 64'(1));

      popped_pc.delete();
      repeat (16) cyc(1'b0, 32'h0, 1'b1);
      check("drain_count", 64'(popped_pc.size()), 64'(15));
      foreach (popped_pc[i]) check("drain_order", 64'(popped_pc[i]), 64'(i * 4));
      check("drain_empty", 64'(iq.Dec_inst_valid), 64'(0));

      // Continuous push/pop: forty entries wrap the pointers twice.
      popped_pc.delete();
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 32'h1000 + 32'(i * 4), 1'b1);
         check("wrap_head", 64'(iq.Dec_pc), 64'(32'h1000 + 32'(i * 4)));
      end
      cyc(1'b0, 32'h0, 1'b1);
      check("wrap_count", 64'(popped_pc.size()), 64'(40));
      foreach (popped_pc[i]) check("wrap_order", 64'(popped_pc[i]), 64'(32'h1000 + 32'(i * 4)));

      // Flush mid-stream with a concurrent push and pop.
      for (int i = 0; i < 5; i++) cyc(1'b1, 32'h200 + 32'(i * 4), 1'b0);
      cyc(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
      check("flush_valid", 64'(iq.Dec_inst_valid), 64'(0));
      cyc(1'b1, 32'h100, 1'b0);
      check("post_flush_pc", 64'(iq.Dec_pc), 64'(32'h100));
      cyc(1'b0, 32'h0, 1'b1);
      check("post_flush_alone", 64'(iq.Dec_inst_valid), 64'(0));

      // Global stall.
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h400 + 32'(i * 4), 1'b0);
      repeat (3) begin
         cyc(1'b1, 32'h500, 1'b1, 1'b0);
         check("stall_pc", 64'(iq.Dec_pc), 64'(32'h400));
      end
      cyc(1'b0, 32'h0, 1'b1);
      check("resume_pc", 64'(iq.Dec_pc), 64'(32'h404));
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Randomised traffic from a conforming fetch stage.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 3) != 0) && !iq.IF_queue_is_full, $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
             $urandom_range(0, 29) == 0);
      end

      // Asynchronous reset between edges with seven entries queued.
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) cyc(1'b1, 32'h600 + 32'(i * 4), 1'b0);
      iq.IF_inst_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_valid", 64'(iq.Dec_inst_valid), 64'(0));
      check("async_rst_full", 64'(iq.IF_queue_is_full), 64'(0));
      @(negedge clk); #1;
      rst = 1'b1;
      cyc(1'b1, 32'h700, 1'b0);
      check("after_rst_pc", 64'(iq.Dec_pc), 64'(32'h700));
      cyc(1'b0, 32'h0, 1'b0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
